tt_capture: RTL and testbench

TT_CAPTURE -- requirements
Module: tt_capture

---
 rtl/tt_pkg.sv | 25 ++
 rtl/tt_settle_timer.sv | 28 ++
 rtl/tt_capture.sv | 112 +++++++++++
 tb/tb_tt_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types, defaults and sizing helper for the truth-table capture block.
package tt_pkg;

    localparam int TT_N_IN_DEF   = 3;
    localparam int TT_N_OUT_DEF  = 2;
    localparam int TT_SETTLE_DEF = 2;
    localparam int TT_CNT_W      = 4;

    typedef enum logic [1:0] {
        TT_IDLE   = 2'd0,
        TT_WAIT   = 2'd1,
        TT_SAMPLE = 2'd2,
        TT_DONE   = 2'd3
    } tt_state_e;

    typedef struct packed {
        logic                load;
        logic [TT_CNT_W-1:0] value;
    } tt_tmr_req_t;

    function automatic int tt_tbl_w(input int n_in, input int n_out);
        return n_out * (2 ** n_in);
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that measures how long a row has been applied before sampling.
module tt_settle_timer
    import tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                en,
    input  logic [TT_CNT_W-1:0] value,
    output logic                done
);

    localparam logic [TT_CNT_W-1:0] CNT_ONE = TT_CNT_W'(1);

    logic [TT_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= value;
        else if (en && cnt_q != '0)
            cnt_q <= cnt_q - CNT_ONE;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/tt_capture.sv
// Sweeps every input combination of a combinational DUT, captures its outputs
// into a table and compares that table against a golden one.
module tt_capture
    import tt_pkg::*;
#(
    parameter int N_IN   = TT_N_IN_DEF,
    parameter int N_OUT  = TT_N_OUT_DEF,
    parameter int SETTLE = TT_SETTLE_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic [N_IN-1:0]                    drive,
    input  logic [N_OUT-1:0]                   sense,
    input  logic [tt_tbl_w(N_IN, N_OUT)-1:0]   expect_tbl,
    output logic [tt_tbl_w(N_IN, N_OUT)-1:0]   table_data,
    output logic                               table_valid,
    input  logic                               table_ready,
    output logic                               mismatch
);

    localparam int ROWS = 2 ** N_IN;

    localparam logic [1:0] S_IDLE   = TT_IDLE;
    localparam logic [1:0] S_WAIT   = TT_WAIT;
    localparam logic [1:0] S_SAMPLE = TT_SAMPLE;
    localparam logic [1:0] S_DONE   = TT_DONE;

    // One extra bit so the last-row compare can never alias after increment.
    localparam logic [N_IN:0]         LAST_ROW  = (N_IN + 1)'(ROWS - 1);
    localparam logic [N_IN:0]         ROW_ONE   = (N_IN + 1)'(1);
    localparam logic [TT_CNT_W-1:0]   SETTLE_LD = TT_CNT_W'(SETTLE - 1);

    logic [1:0]                   state_q;
    logic [N_IN:0]                row_q;
    logic [ROWS-1:0][N_OUT-1:0]   tbl_q;
    logic [ROWS-1:0][N_OUT-1:0]   tbl_nxt;
    logic                         mismatch_q;
    logic                         tmr_done;
    tt_tmr_req_t                  tmr_req;

    always_comb begin
        tmr_req       = '0;
        tmr_req.value = SETTLE_LD;
        tmr_req.load  = (state_q == S_IDLE && start) ||
                        (state_q == S_SAMPLE && row_q != LAST_ROW);
    end

    tt_settle_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_req.load),
        .en    (state_q == S_WAIT),
        .value (tmr_req.value),
        .done  (tmr_done)
    );

    // Only the slot addressed by the current row can change, and only in SAMPLE.
    for (genvar r = 0; r < ROWS; r++) begin : g_slot
        assign tbl_nxt[r] = (state_q == S_SAMPLE && row_q == (N_IN + 1)'(r))
                            ? sense : tbl_q[r];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            tbl_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_WAIT;
                        row_q      <= '0;
                        tbl_q      <= '0;
                        mismatch_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (tmr_done)
                        state_q <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    tbl_q <= tbl_nxt;
                    if (row_q == LAST_ROW) begin
                        state_q    <= S_DONE;
                        mismatch_q <= (tbl_nxt != expect_tbl);
                    end else begin
                        row_q   <= row_q + ROW_ONE;
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    if (table_ready) begin
                        state_q <= S_IDLE;
                        row_q   <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign drive       = row_q[N_IN-1:0];
    assign busy        = (state_q != S_IDLE);
    assign table_valid = (state_q == S_DONE);
    assign table_data  = tbl_q;
    assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_tt_capture.sv
// Scoreboard bench: drivers push expected tables, monitors pop on table_valid.
module tb_tt_capture;

    localparam int N_OUT = 2;
    localparam int ROWS  = 8;
    localparam int LAT   = ROWS * (2 + 1);
    localparam int ROWS2 = 4;
    localparam int LAT2  = ROWS2 * (1 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0, ready = 1'b0;
    logic        busy, tv, mm;
    logic [2:0]  drive;
    logic [1:0]  sense;
    logic [15:0] exp_tbl = '0, tdata;

    logic        start2 = 1'b0, ready2 = 1'b0;
    logic        busy2, tv2, mm2;
    logic [1:0]  drive2;
    logic [0:0]  sense2;
    logic [3:0]  exp_tbl2 = '0, tdata2;

    // Behavioural DUT models: a lookup table for the default instance, AND for the small one.
    logic [1:0] truth [ROWS];
    logic       ovr_en = 1'b0;
    logic [1:0] ovr_val = 2'b01;
    assign sense  = ovr_en ? ovr_val : truth[drive];
    assign sense2 = drive2[0] & drive2[1];

    tt_capture dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .drive(drive), .sense(sense),
        .expect_tbl(exp_tbl), .table_data(tdata), .table_valid(tv),
        .table_ready(ready), .mismatch(mm)
    );

    tt_capture #(.N_IN(2), .N_OUT(1), .SETTLE(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .drive(drive2), .sense(sense2),
        .expect_tbl(exp_tbl2), .table_data(tdata2), .table_valid(tv2),
        .table_ready(ready2), .mismatch(mm2)
    );

    typedef struct {
        logic [15:0] tbl;
        logic        mm;
        int          lat;
    } exp_t;

    exp_t sbq [$];
    exp_t sbq2 [$];
    int pass_cnt = 0, total = 0;
    int cyc = 0, t0 = 0, t0_2 = 0;
    logic tv_d = 1'b0, tv2_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act == expv) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    always @(negedge clk) begin
        if (tv && !tv_d) begin
            if (sbq.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                check("table_data", int'(tdata), int'(e.tbl));
                check("mismatch", int'(mm), int'(e.mm));
                check("latency", cyc - t0, e.lat);
            end
        end
        tv_d <= tv;
    end

    always @(negedge clk) begin
        if (tv2 && !tv2_d) begin
            if (sbq2.size() == 0) check("unexpected_valid2", 1, 0);
            else begin
                exp_t e;
                e = sbq2.pop_front();
                check("table_data2", int'(tdata2), int'(e.tbl));
                check("mismatch2", int'(mm2), int'(e.mm));
                check("latency2", cyc - t0_2, e.lat);
            end
        end
        tv2_d <= tv2;
    end

    function automatic logic [15:0] model_tbl();
        logic [15:0] t;
        t = '0;
        for (int r = 0; r < ROWS; r++) t[r*N_OUT +: N_OUT] = truth[r];
        return t;
    endfunction

    function automatic logic [3:0] model_and();
        logic [3:0] t;
        t = '0;
        for (int r = 0; r < ROWS2; r++) t[r] = ((r % 2) == 1) && ((r / 2) == 1);
        return t;
    endfunction

    task automatic push(input bit d2, input logic [15:0] tbl, input logic [15:0] golden);
        exp_t e;
        e.tbl = tbl;
        e.mm  = (tbl != golden);
        e.lat = d2 ? LAT2 : LAT;
        if (d2) sbq2.push_back(e); else sbq.push_back(e);
    endtask

    task automatic do_start(input bit d2);
        if (d2) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        if (d2) begin t0_2 = cyc; start2 = 1'b0; end
        else begin t0 = cyc; start = 1'b0; end
    endtask

    task automatic finish_sweep(input bit d2);
        int n = 0;
        while (!(d2 ? tv2 : tv) && n < 200) begin @(posedge clk); #1; n++; end
        if (!(d2 ? tv2 : tv)) begin check("valid_timeout", 0, 1); return; end
        if (d2) ready2 = 1'b1; else ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0; ready2 = 1'b0;
        check("idle_after_ack", int'(d2 ? busy2 : busy), 0);
        check("drive_zero_in_idle", int'(d2 ? {1'b0, drive2} : drive), 0);
    endtask

    task automatic set_default_truth();
        truth[0] = 2'b11; truth[1] = 2'b00; truth[2] = 2'b11; truth[3] = 2'b10;
        truth[4] = 2'b11; truth[5] = 2'b00; truth[6] = 2'b10; truth[7] = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] golden, alt;
        set_default_truth();
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(tv), 0);
        check("rst_drive", int'(drive), 0);
        check("rst_table", int'(tdata), 0);
        check("rst_mismatch", int'(mm), 0);
        rst = 1'b0;

        // Scenario 1 and 2: golden match, then a single-bit golden difference.
        golden = model_tbl();
        check("model_default_table", int'(golden), 'h23B3);
        exp_tbl = 16'h23B3; push(0, golden, exp_tbl); do_start(0); finish_sweep(0);
        exp_tbl = 16'h23B7; push(0, golden, exp_tbl); do_start(0); finish_sweep(0);

        // Scenario 3: consumer stalls while start is toggled.
        exp_tbl = 16'h23B3; push(0, golden, exp_tbl); do_start(0);
        repeat (LAT) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            check("hold_table", int'(tdata), 'h23B3);
            check("hold_mismatch", int'(mm), 0);
            check("hold_busy_valid", int'({busy, tv}), 3);
            start = k[0];
            @(posedge clk); #1;
        end
        start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ready = 1'b0;
        check("ack_to_idle", int'(busy), 0);
        @(posedge clk); #1;
        check("start_in_ack_ignored", int'(busy), 0);

        // Scenario 4: reset in the middle of row 3.
        do_start(0);
        repeat (10) @(posedge clk);
        #1;
        check("pre_reset_row", int'(drive), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_drive", int'(drive), 0);
        check("midrst_table", int'(tdata), 0);
        check("midrst_valid", int'(tv), 0);
        push(0, golden, exp_tbl); do_start(0); finish_sweep(0);

        // Scenario 5: drive sequence, and a sense glitch confined to row 5's sample cycle.
        alt = golden;
        alt[5*N_OUT +: N_OUT] = ovr_val;
        push(0, alt, exp_tbl); do_start(0);
        for (int k = 0; k < LAT; k++) begin
            check("drive_seq", int'(drive), k / 3);
            ovr_en = (k == 17);
            @(posedge clk); #1;
        end
        ovr_en = 1'b0;
        check("drive_hold_done", int'(drive), ROWS - 1);
        finish_sweep(0);

        // Randomized tables with golden either matching or off by one bit.
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < ROWS; r++) truth[r] = 2'($urandom_range(0, 3));
            golden = model_tbl();
            exp_tbl = golden;
            if ($urandom_range(0, 1) == 1) exp_tbl[$urandom_range(0, 15)] ^= 1'b1;
            push(0, golden, exp_tbl); do_start(0); finish_sweep(0);
        end

        // Scenario 6: small instance sensing a 2-input AND.
        exp_tbl2 = 4'b1000; push(1, {12'h0, model_and()}, {12'h0, exp_tbl2});
        do_start(1); finish_sweep(1);
        exp_tbl2 = 4'b0000; push(1, {12'h0, model_and()}, {12'h0, exp_tbl2});
        do_start(1); finish_sweep(1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sbq.size() + sbq2.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
